// File: rtl/alu_acc_sequencer.sv
// Moore control sequencer for an accumulator/ALU datapath: single-cycle LDA/ADD/SUB/AND
// and four-iteration shift-add multiply / shift-subtract divide.
module alu_acc_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic       abort,
    input  logic       zero_flag_in,
    input  logic       sign_flag_in,
    output logic       op_add,
    output logic       op_sub,
    output logic       op_mul,
    output logic       op_div,
    output logic       op_and,
    output logic       rd_en,
    output logic       acc_in_select,
    output logic       acc_high_reset_p,
    output logic [1:0] acc_high_select,
    output logic [1:0] acc_low_select,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       flag_z,
    output logic       flag_s
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_EXEC, S_MUL_ADD, S_MUL_SHF, S_DIV_SHF, S_DIV_SUB, S_DONE
    } state_t;

    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;

    state_t     r_state;
    state_t     w_stateNext;
    logic [1:0] r_cnt;
    logic [2:0] r_opcode;
    logic       r_err;
    logic       r_flagZ;
    logic       r_flagS;
    logic       w_accept;
    logic       w_illegal;
    logic       w_abortActive;

    assign w_accept      = (r_state == S_IDLE) && start && !abort;
    assign w_illegal     = (opcode == 3'b000) || (opcode == 3'b111);
    assign w_abortActive = abort && (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_AND: w_stateNext = S_EXEC;
                        OP_MUL, OP_DIV:                 w_stateNext = S_LOAD;
                        default:                        w_stateNext = S_DONE;
                    endcase
                end
            end
            S_LOAD:    w_stateNext = (r_opcode == OP_MUL) ? S_MUL_ADD : S_DIV_SHF;
            S_EXEC:    w_stateNext = S_DONE;
            S_MUL_ADD: w_stateNext = S_MUL_SHF;
            S_MUL_SHF: w_stateNext = (r_cnt == 2'd3) ? S_DONE : S_MUL_ADD;
            S_DIV_SHF: w_stateNext = S_DIV_SUB;
            S_DIV_SUB: w_stateNext = (r_cnt == 2'd3) ? S_DONE : S_DIV_SHF;
            S_DONE:    w_stateNext = S_IDLE;
            default:   w_stateNext = S_IDLE;
        endcase
        if (w_abortActive) begin
            w_stateNext = S_IDLE;
        end
    end

    // The counter rolls 3->0 naturally on the last increment, which is also the exit to DONE.
    // An abort skips the DONE flag capture so the previous command's flags survive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= 2'd0;
            r_opcode <= 3'b000;
            r_err    <= 1'b0;
            r_flagZ  <= 1'b0;
            r_flagS  <= 1'b0;
        end else if (w_abortActive) begin
            r_cnt <= 2'd0;
        end else begin
            if (w_accept) begin
                r_opcode <= opcode;
                r_err    <= w_illegal;
            end
            case (r_state)
                S_LOAD:               r_cnt <= 2'd0;
                S_MUL_SHF, S_DIV_SUB: r_cnt <= r_cnt + 2'd1;
                S_DONE: begin
                    r_flagZ <= zero_flag_in;
                    r_flagS <= sign_flag_in;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        op_add           = 1'b0;
        op_sub           = 1'b0;
        op_mul           = 1'b0;
        op_div           = 1'b0;
        op_and           = 1'b0;
        rd_en            = 1'b0;
        acc_in_select    = 1'b0;
        acc_high_reset_p = 1'b0;
        acc_high_select  = 2'b00;
        acc_low_select   = 2'b00;
        busy             = (r_state != S_IDLE);
        done             = (r_state == S_DONE);
        err              = r_err;
        flag_z           = r_flagZ;
        flag_s           = r_flagS;
        case (r_state)
            S_LOAD: begin
                rd_en            = 1'b1;
                acc_low_select   = 2'b11;
                acc_high_reset_p = 1'b1;
            end
            S_EXEC: begin
                if (r_opcode == OP_LDA) begin
                    rd_en          = 1'b1;
                    acc_low_select = 2'b11;
                end else begin
                    op_add          = (r_opcode == OP_ADD);
                    op_sub          = (r_opcode == OP_SUB);
                    op_and          = (r_opcode == OP_AND);
                    acc_in_select   = 1'b1;
                    acc_high_select = 2'b11;
                end
            end
            S_MUL_ADD: begin
                op_mul        = 1'b1;
                acc_in_select = 1'b1;
            end
            S_MUL_SHF: begin
                op_mul          = 1'b1;
                acc_high_select = 2'b01;
                acc_low_select  = 2'b01;
            end
            S_DIV_SHF: begin
                op_div          = 1'b1;
                acc_high_select = 2'b10;
                acc_low_select  = 2'b10;
            end
            S_DIV_SUB: begin
                op_div        = 1'b1;
                acc_in_select = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Scoreboard bench for alu_acc_sequencer: the driver queues per-cycle expectations and
// completion records, and a negedge monitor compares them against the DUT.
module tb_alu_acc_sequencer;

    typedef struct {
        int          cyc;
        logic [16:0] obs;
    } traceEntry_t;

    typedef struct {
        int   issueCyc;
        int   latency;
        logic err;
    } resultEntry_t;

    localparam logic [11:0] C_ADD   = 12'b1000_0000_0000;
    localparam logic [11:0] C_SUB   = 12'b0100_0000_0000;
    localparam logic [11:0] C_MUL   = 12'b0010_0000_0000;
    localparam logic [11:0] C_DIV   = 12'b0001_0000_0000;
    localparam logic [11:0] C_AND   = 12'b0000_1000_0000;
    localparam logic [11:0] C_RD    = 12'b0000_0100_0000;
    localparam logic [11:0] C_INSEL = 12'b0000_0010_0000;
    localparam logic [11:0] C_HRST  = 12'b0000_0001_0000;
    localparam logic [11:0] C_H11   = 12'b0000_0000_1100;
    localparam logic [11:0] C_H10   = 12'b0000_0000_1000;
    localparam logic [11:0] C_H01   = 12'b0000_0000_0100;
    localparam logic [11:0] C_L11   = 12'b0000_0000_0011;
    localparam logic [11:0] C_L10   = 12'b0000_0000_0010;
    localparam logic [11:0] C_L01   = 12'b0000_0000_0001;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic       abort = 1'b0;
    logic       zero_flag_in = 1'b0;
    logic       sign_flag_in = 1'b0;
    logic       op_add, op_sub, op_mul, op_div, op_and;
    logic       rd_en, acc_in_select, acc_high_reset_p;
    logic [1:0] acc_high_select, acc_low_select;
    logic       busy, done, err, flag_z, flag_s;

    logic [11:0] obsCtl;
    logic [16:0] obsAll;

    int cycle = 0;
    int errors = 0;
    int checks = 0;
    logic modelZ = 1'b0;
    logic modelS = 1'b0;
    logic modelErr = 1'b0;

    traceEntry_t  traceQ[$];
    resultEntry_t resQ[$];
    traceEntry_t  monTrace;
    resultEntry_t monRes;

    alu_acc_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .abort(abort),
        .zero_flag_in(zero_flag_in), .sign_flag_in(sign_flag_in),
        .op_add(op_add), .op_sub(op_sub), .op_mul(op_mul), .op_div(op_div), .op_and(op_and),
        .rd_en(rd_en), .acc_in_select(acc_in_select), .acc_high_reset_p(acc_high_reset_p),
        .acc_high_select(acc_high_select), .acc_low_select(acc_low_select),
        .busy(busy), .done(done), .err(err), .flag_z(flag_z), .flag_s(flag_s)
    );

    assign obsCtl = {op_add, op_sub, op_mul, op_div, op_and, rd_en, acc_in_select,
                     acc_high_reset_p, acc_high_select, acc_low_select};
    assign obsAll = {busy, done, err, flag_z, flag_s, obsCtl};

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Cycle k (1-based after the start edge) of each command and the cycle on which done appears.
    function automatic int cmdLen(input logic [2:0] op);
        case (op)
            3'b001, 3'b010, 3'b011, 3'b100: return 2;
            3'b101, 3'b110:                 return 10;
            default:                        return 1;
        endcase
    endfunction

    function automatic logic [11:0] expCtl(input logic [2:0] op, input int k);
        case (op)
            3'b001: return C_RD | C_L11;
            3'b010: return C_ADD | C_INSEL | C_H11;
            3'b011: return C_SUB | C_INSEL | C_H11;
            3'b100: return C_AND | C_INSEL | C_H11;
            3'b101: begin
                if (k == 1) return C_RD | C_L11 | C_HRST;
                if (k % 2 == 0) return C_MUL | C_INSEL;
                return C_MUL | C_H01 | C_L01;
            end
            3'b110: begin
                if (k == 1) return C_RD | C_L11 | C_HRST;
                if (k % 2 == 0) return C_DIV | C_H10 | C_L10;
                return C_DIV | C_INSEL;
            end
            default: return 12'h000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after.
    task automatic applyStimulus(input logic [2:0] op, input logic fz, input logic fs,
                                 input int abortAt, input bit noise);
        traceEntry_t ent;
        resultEntry_t res;
        int   len;
        int   last;
        int   c0;
        logic e;
        bit   aborted;
        len     = cmdLen(op);
        e       = (op == 3'b000) || (op == 3'b111);
        c0      = cycle;
        aborted = (abortAt > 0);
        last    = aborted ? abortAt : len;
        for (int k = 1; k <= last; k++) begin
            ent.cyc = c0 + k;
            ent.obs = {1'b1, (k == len), e, modelZ, modelS, (k == len) ? 12'h000 : expCtl(op, k)};
            traceQ.push_back(ent);
        end
        ent.cyc = c0 + last + 1;
        ent.obs = aborted ? {2'b00, e, modelZ, modelS, 12'h000} : {2'b00, e, fz, fs, 12'h000};
        traceQ.push_back(ent);
        if (!aborted) begin
            res.issueCyc = c0;
            res.latency  = len;
            res.err      = e;
            resQ.push_back(res);
            modelZ = fz;
            modelS = fs;
        end
        modelErr = e;
        opcode       = op;
        start        = 1'b1;
        abort        = 1'b0;
        zero_flag_in = fz;
        sign_flag_in = fs;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (start) opcode = 3'($urandom_range(0, 7));
            abort = (k == abortAt);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic applyAbortInIdle();
        traceEntry_t ent;
        ent.cyc = cycle + 1;
        ent.obs = {2'b00, modelErr, modelZ, modelS, 12'h000};
        traceQ.push_back(ent);
        opcode = 3'b010;
        start  = 1'b1;
        abort  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic applyResetMidDiv();
        opcode = 3'b110;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        modelZ   = 1'b0;
        modelS   = 1'b0;
        modelErr = 1'b0;
        #1 checkOutput("asyncResetMidDiv", 32'(obsAll), 32'h0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: consumes trace entries by cycle and completion records whenever done is seen.
    always @(negedge clk) begin
        if (reset_n) begin
            while (traceQ.size() > 0 && traceQ[0].cyc < cycle) begin
                monTrace = traceQ.pop_front();
                checkOutput("traceMissed", 32'(cycle), 32'(monTrace.cyc));
            end
            if (traceQ.size() > 0 && traceQ[0].cyc == cycle) begin
                monTrace = traceQ.pop_front();
                checkOutput("cycleTrace", 32'(obsAll), 32'(monTrace.obs));
            end
            if (done) begin
                if (resQ.size() == 0) begin
                    checkOutput("unexpectedDone", 32'(done), 32'h0);
                end else begin
                    monRes = resQ.pop_front();
                    checkOutput("doneLatency", 32'(cycle - monRes.issueCyc), 32'(monRes.latency));
                    checkOutput("doneErr", 32'(err), 32'(monRes.err));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] op;
        int         len;
        int         abortAt;
        #1 reset_n = 1'b0;
        #2 checkOutput("resetOutputs", 32'(obsAll), 32'h0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);

        applyStimulus(3'b010, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(3'b101, 1'b1, 1'b0, 0, 1'b1);
        applyStimulus(3'b110, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus(3'b101, 1'b0, 1'b1, 5, 1'b1);
        applyStimulus(3'b111, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(3'b010, 1'b1, 1'b1, 0, 1'b0);
        applyAbortInIdle();
        applyStimulus(3'b000, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus(3'b001, 1'b0, 1'b0, 0, 1'b1);
        applyResetMidDiv();
        applyStimulus(3'b001, 1'b1, 1'b0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) applyAbortInIdle();
            op      = 3'($urandom_range(0, 7));
            len     = cmdLen(op);
            abortAt = (len > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : 0;
            applyStimulus(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), abortAt, 1'b1);
        end

        for (int i = 0; i < 50 && traceQ.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checkOutput("queuesDrained", 32'(traceQ.size() + resQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
